// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the M-extension sequencer: funct3 codes, multiplier selects, FSM states.
package mdu_ctrl_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [1:0] MSEL_UNSIGNED        = 2'd0;
    localparam logic [1:0] MSEL_SIGNED          = 2'd1;
    localparam logic [1:0] MSEL_SIGNED_UNSIGNED = 2'd2;

    localparam int              CNT_W          = 5;
    localparam logic [CNT_W-1:0] DIV_STEP_FIRST = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic logic [1:0] mul_sel_of(input logic [2:0] op);
        case (op)
            OP_MULH:   return MSEL_SIGNED;
            OP_MULHSU: return MSEL_SIGNED_UNSIGNED;
            default:   return MSEL_UNSIGNED;
        endcase
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Restoring shift/subtract divider datapath on unsigned magnitudes, one quotient bit per step.
module div_core #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nrst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    logic [W-1:0] rem_q, quo_q, dvs_q;
    logic [W:0]   shifted;
    logic         fits;
    logic [W-1:0] diff;

    // Partial remainder needs one extra bit before the trial subtract.
    assign shifted = {rem_q, quo_q[W-1]};
    assign fits    = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[W-1:0] - dvs_q;

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? diff : shifted[W-1:0];
            quo_q <= {quo_q[W-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/mdu_ctrl.sv
// M-extension sequencer: steers an external multiplier IP and an iterative divider, with sign fixup.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int MUL_LAT    = 1
) (
    input  logic                    CLK,
    input  logic                    nrst,
    input  logic                    req_valid,
    input  logic [2:0]              req_op,
    input  logic [WORD_WIDTH-1:0]   op_a,
    input  logic [WORD_WIDTH-1:0]   op_b,
    input  logic                    hold,
    input  logic                    flush,
    output logic                    mul_ce,
    output logic [1:0]              mul_sel,
    input  logic [2*WORD_WIDTH-1:0] mul_p,
    output logic [WORD_WIDTH-1:0]   res,
    output logic                    stall,
    output logic                    done,
    output state_t                  dbg_state
);
    localparam int           W       = WORD_WIDTH;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q;
    logic             neg_quo_q, neg_rem_q;
    logic [W-1:0]     res_q;
    logic [1:0]       mul_sel_q;

    logic         accept, req_div, req_sgn, req_rem, b_zero, ovf, special;
    logic         div_load, div_step;
    logic [W-1:0] abs_a, abs_b, special_res, dq, dr, fix_quo, fix_rem, fix_res;

    // Handshake: a request is taken only in IDLE, when req_valid=1 and neither hold nor flush is
    // asserted; stall rises in that same cycle and stays high until the DONE cycle.
    assign accept  = nrst && (state_q == ST_IDLE) && req_valid && !hold && !flush;
    assign req_div = req_op[2];
    assign req_sgn = ~req_op[0];
    assign req_rem = req_op[1];
    assign b_zero  = (op_b == '0);
    assign ovf     = req_sgn && (op_a == MIN_NEG) && (op_b == '1);
    assign special = b_zero || ovf;
    assign abs_a   = (req_sgn && op_a[W-1]) ? -op_a : op_a;
    assign abs_b   = (req_sgn && op_b[W-1]) ? -op_b : op_b;

    always_comb begin
        special_res = '0;
        if (b_zero) special_res = req_rem ? op_a : '1;
        else        special_res = req_rem ? '0 : MIN_NEG;
    end

    assign div_load = accept && req_div && !special;
    assign div_step = (state_q == ST_DIV_RUN) && !hold && !flush;

    div_core #(.W(W)) u_div (
        .CLK       (CLK),
        .nrst      (nrst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (dq),
        .remainder (dr)
    );

    assign fix_quo = neg_quo_q ? -dq : dq;
    assign fix_rem = neg_rem_q ? -dr : dr;
    assign fix_res = op_q[1] ? fix_rem : fix_quo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!req_div) begin
                            state_d = ST_MUL_WAIT;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                        end else if (special) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DIV_RUN;
                            cnt_d   = DIV_STEP_FIRST;
                        end
                    end
                end
                ST_MUL_WAIT: if (!hold) begin
                    if (cnt_q == '0) state_d = ST_DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_DIV_RUN: if (!hold) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = ST_DIV_FIX;
                end
                ST_DIV_FIX: if (!hold) state_d = ST_DONE;
                ST_DONE:    if (!hold) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            mul_sel_q <= MSEL_UNSIGNED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q      <= req_op;
                neg_quo_q <= req_sgn && (op_a[W-1] ^ op_b[W-1]);
                neg_rem_q <= req_sgn && op_a[W-1];
                if (!req_div)           mul_sel_q <= mul_sel_of(req_op);
                if (req_div && special) res_q     <= special_res;
            end
            if ((state_q == ST_DIV_FIX) && !hold && !flush) res_q <= fix_res;
        end
    end

    // Multiply results come straight from the IP, which holds its product while mul_ce is low.
    assign done      = (state_q == ST_DONE);
    assign stall     = accept || (state_q inside {ST_MUL_WAIT, ST_DIV_RUN, ST_DIV_FIX});
    assign mul_ce    = (state_q == ST_MUL_WAIT) && !hold && !flush;
    assign mul_sel   = mul_sel_q;
    assign dbg_state = state_q;
    assign res       = !done      ? '0 :
                       op_q[2]    ? res_q :
                       (op_q == OP_MUL) ? mul_p[W-1:0] : mul_p[2*W-1:W];
endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl with a multiplier IP model and a queued scoreboard.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 1;

    logic           CLK, nrst, req_valid, hold, flush;
    logic [2:0]     req_op;
    logic [W-1:0]   op_a, op_b, res;
    logic           mul_ce, stall, done;
    logic [1:0]     mul_sel;
    logic [2*W-1:0] mul_p;
    state_t         dbg_state;

    int             checks = 0;
    int             errors = 0;
    int             cyc    = 0;
    logic [W-1:0]   exp_q[$];
    int             cyc_q[$];
    logic [W-1:0]   cur_exp;
    int             cur_cyc;
    bit             have_cur  = 0;
    bit             done_prev = 0;
    logic [2*W-1:0] ip_pipe [MUL_LAT];

    mdu_ctrl #(.WORD_WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
        .CLK       (CLK),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .hold      (hold),
        .flush     (flush),
        .mul_ce    (mul_ce),
        .mul_sel   (mul_sel),
        .mul_p     (mul_p),
        .res       (res),
        .stall     (stall),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial CLK = 0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Multiplier IP model: MUL_LAT-stage pipeline advancing on mul_ce
    function automatic logic [63:0] ip_prod(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (sel)
            2'd1:    return 64'(sa * sb);
            2'd2:    return 64'(sa * longint'(ub));
            default: return 64'(ua * ub);
        endcase
    endfunction

    always @(posedge CLK) begin
        if (mul_ce) begin
            ip_pipe[0] <= ip_prod(mul_sel, op_a, op_b);
            for (int i = 1; i < MUL_LAT; i++) ip_pipe[i] <= ip_pipe[i-1];
        end
    end
    assign mul_p = ip_pipe[MUL_LAT-1];

    // Reference model from the architectural definition of each M op
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        bit              ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub);          return p[31:0];  end
            3'd1: begin p = 64'(sa * sb);          return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub);          return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return MUL_LAT + 1;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(5, 0))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(20, 0));
            4:       return -32'($urandom_range(20, 1));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done pulse, checks value and arrival cycle
    always @(negedge CLK) begin
        if (done) begin
            if (!done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    have_cur = 0;
                    $display("FAIL unexpected_done: got res %h with no op outstanding (cycle %0d)", res, cyc);
                end else begin
                    cur_exp  = exp_q.pop_front();
                    cur_cyc  = cyc_q.pop_front();
                    have_cur = 1;
                    check("done_cycle", W'(cyc), W'(cur_cyc));
                end
            end
            if (have_cur) check("res", res, cur_exp);
            check("stall_in_done", W'(stall), '0);
        end
        done_prev = done;
    end

    // Driver: present a request, wait for acceptance
    task automatic wait_accept(output bit ok, output int acc);
        ok  = 0;
        acc = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge CLK);
            ok = stall;
        end
        acc = cyc;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got stall 0 expected 1 within 100 cycles");
        end
    endtask

    // Driver: one op with optional hold window and flush, relative to the acceptance cycle
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold_at, input int hold_len, input int flush_at);
        int lat, acc, k;
        bit ok;
        lat       = lat_of(op, a, b);
        req_valid = 1;
        req_op    = op;
        op_a      = a;
        op_b      = b;
        wait_accept(ok, acc);
        if (!ok) begin
            req_valid = 0;
            return;
        end
        if (flush_at < 0) begin
            exp_q.push_back(ref_res(op, a, b));
            cyc_q.push_back(acc + lat + ((hold_len > 0 && hold_at < lat) ? hold_len : 0));
        end
        @(posedge CLK);
        #1 req_valid = 0;
        for (k = 1; k < 200; k++) begin
            hold  = (hold_len > 0) && (k >= hold_at) && (k < hold_at + hold_len);
            flush = (k == flush_at);
            @(negedge CLK);
            if (hold) check("mul_ce_hold", W'(mul_ce), '0);
            if (flush_at >= 0 && k == flush_at + 1) begin
                check("flush_idle", W'(dbg_state), W'(ST_IDLE));
                check("flush_stall", W'(stall), '0);
                check("flush_done", W'(done), '0);
                break;
            end
            if (flush_at < 0 && done && !hold) break;
            @(posedge CLK);
            #1;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got no completion expected done within 200 cycles");
        end
        hold  = 0;
        flush = 0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit ok;
        int acc, lat, h_at, h_len;
        logic [2:0]   r_op;
        logic [W-1:0] r_a, r_b;

        nrst      = 0;
        req_valid = 1;
        req_op    = OP_MUL;
        op_a      = 32'd3;
        op_b      = 32'd4;
        hold      = 0;
        flush     = 0;
        #12;
        check("rst_stall", W'(stall), '0);
        check("rst_done", W'(done), '0);
        check("rst_mul_ce", W'(mul_ce), '0);
        check("rst_mul_sel", W'(mul_sel), '0);
        check("rst_res", res, '0);
        check("rst_state", W'(dbg_state), W'(ST_IDLE));
        req_valid = 0;
        @(posedge CLK);
        #1 nrst = 1;
        @(posedge CLK);
        #1;

        // Directed cases
        run_op(OP_MUL, 32'd7, 32'd6, 0, 0, -1);
        run_op(OP_DIV, -32'd20, 32'd3, 0, 0, -1);
        run_op(OP_REM, -32'd20, 32'd3, 0, 0, -1);
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, 0, 0, -1);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1);
        run_op(OP_REMU, 32'hDEAD_BEEF, 32'd0, 0, 0, -1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1);
        run_op(OP_DIV, 32'd1000, -32'd7, 10, 3, -1);
        run_op(OP_REM, -32'd20, 32'd3, 34, 2, -1);
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd3, 1, 2, -1);
        run_op(OP_DIV, 32'd100, 32'd7, 0, 0, 10);
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 0, 0, -1);
        run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 0, 0, -1);

        // Request under hold in IDLE is not taken
        hold      = 1;
        req_valid = 1;
        req_op    = OP_DIVU;
        op_a      = 32'd9;
        op_b      = 32'd2;
        repeat (3) begin
            @(negedge CLK);
            check("hold_idle_stall", W'(stall), '0);
            check("hold_idle_state", W'(dbg_state), W'(ST_IDLE));
        end
        @(posedge CLK);
        #1 hold = 0;
        run_op(OP_DIVU, 32'd9, 32'd2, 0, 0, -1);

        // Asynchronous reset while in MUL_WAIT
        req_valid = 1;
        req_op    = OP_MULH;
        op_a      = 32'd5;
        op_b      = 32'd7;
        wait_accept(ok, acc);
        @(posedge CLK);
        #1 req_valid = 0;
        check("mulwait_ce", W'(mul_ce), 32'd1);
        check("mulwait_sel", W'(mul_sel), W'(MSEL_SIGNED));
        #2 nrst = 0;
        #1;
        check("arst_stall", W'(stall), '0);
        check("arst_mul_ce", W'(mul_ce), '0);
        check("arst_mul_sel", W'(mul_sel), '0);
        check("arst_done", W'(done), '0);
        check("arst_res", res, '0);
        check("arst_state", W'(dbg_state), W'(ST_IDLE));
        @(posedge CLK);
        #2 nrst = 1;
        repeat (5) @(posedge CLK);
        #1;
        run_op(OP_MUL, 32'd123, 32'd456, 0, 0, -1);

        // Randomized ops with occasional hold windows
        for (int n = 0; n < 40; n++) begin
            r_op  = 3'($urandom_range(7, 0));
            r_a   = pick_val();
            r_b   = pick_val();
            lat   = lat_of(r_op, r_a, r_b);
            h_len = 0;
            h_at  = 0;
            if ($urandom_range(3, 0) == 0) begin
                h_at  = int'($urandom_range(lat, 1));
                h_len = int'($urandom_range(3, 1));
            end
            run_op(r_op, r_a, r_b, h_at, h_len, -1);
        end

        repeat (3) @(posedge CLK);
        #1;
        check("queue_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
